game_uart_link: RTL and testbench
=================================

Name: game_uart_link

Overview:
- Parametrised PC-link protocol engine between the UART rx/tx cores and the game logic.
- Decodes multi-byte PC commands: start, indexed hit, and score query.
- Queues FPGA-to-PC event bytes (mole change, game over, score report, optional echo) in a TX FIFO and drains it with a proper tx_busy handshake.
- Replaces the ad-hoc single-byte decode and echo logic in the top level, and supports any mole count.

Parameters:
- NUM_MOLES, 5: mole channels, 1..10; indices are sent as ASCII '0'..'9'.
- FIFO_DEPTH, 8: TX byte FIFO depth, power of 2, at least 4.
- ECHO_EN, 0: when 1, every received byte is also queued back to the PC.
- SCORE_BITS, 6: score width, 1..8.

Ports:
- clock  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-low.
- rx_data  in  8  byte from uart_rx.
- rx_ready  in  1  one-cycle strobe: rx_data is valid.
- tx_busy  in  1  uart_tx busy; rises the cycle after tx_start and stays high until the stop bit completes.
- tx_start  out  1  one-cycle send strobe to uart_tx.
- tx_data  out  8  byte to send; held stable from tx_start until tx_busy falls.
- game_active  in  1  level from the game FSM.
- game_over  in  1  level, high in the FSM FINISH state.
- mole_positions  in  NUM_MOLES  current mole LEDs.
- score  in  SCORE_BITS  current score.
- cmd_start  out  1  one-cycle pulse.
- cmd_hit  out  1  one-cycle pulse.
- cmd_hit_onehot  out  NUM_MOLES  one-hot hit index, valid only while cmd_hit is high; zero otherwise.
- rx_error  out  1  one-cycle pulse on a malformed command.
- drop_flag  out  1  sticky; set when any outgoing byte is lost.

Behaviour:
Reset:
- All outputs go to 0.
- FIFO empty; RX and TX FSMs in IDLE; last_mole = 0; over_armed = 1; all pending flags clear.
- Reset asserted mid-transfer abandons the current byte and flushes the FIFO.

RX parser (states RX_IDLE, RX_IDX), acting only on cycles where rx_ready = 1. All command outputs are registered and appear in the cycle after rx_ready.
- RX_IDLE, byte 'S': pulse cmd_start.
- RX_IDLE, byte 'H': go to RX_IDX.
- RX_IDLE, byte 'Q': set pend_score.
- RX_IDLE, any other byte: ignored, no error.
- RX_IDX, byte '0'+k with k < NUM_MOLES: pulse cmd_hit with cmd_hit_onehot bit k set; go to RX_IDLE.
- RX_IDX, any other byte (including 'S'): pulse rx_error; byte is discarded; go to RX_IDLE.
- ECHO_EN = 1: the received byte also sets pend_echo with that value. A new echo byte arriving while pend_echo is still set overwrites it and sets drop_flag.

Event detection (registered):
- Mole change: game_active = 1 and mole_positions != last_mole. Update last_mole and set pend_mole with code:
  - '-' if mole_positions is all zeros;
  - otherwise '0' + index of the lowest set bit.
  - A newer change overwrites an unwritten pend_mole (coalesced; no drop_flag).
- Game over: game_over = 1 and over_armed = 1 sets pend_over and clears over_armed. game_active = 1 re-arms over_armed. 'R' is sent exactly once per game.
- Score report: pend_score produces 2 bytes, 'P' followed by {zero-extend, score}. Score is sampled when the first byte is written.

FIFO write (at most one byte per cycle):
- Priority: score second byte > score 'P' > 'R' > mole code > echo.
- The 'P' byte is written only if at least 2 slots are free. If fewer are free, the whole report is dropped and drop_flag is set.
- Any other write attempted while the FIFO is full clears that pending flag and sets drop_flag.
- Simultaneous write and read in one cycle is legal, including when the FIFO is full (the read frees a slot that cycle).

TX drain FSM:
- TX_IDLE: if the FIFO is non-empty and tx_busy = 0, pop the head, drive tx_data, pulse tx_start, go to TX_WAIT_HI.
- TX_WAIT_HI: go to TX_WAIT_LO when tx_busy = 1.
- TX_WAIT_LO: go to TX_IDLE when tx_busy = 0.
- Throughput: one byte per UART frame plus 2 cycles.
- Latency: event detected at cycle N, FIFO write at N+1, tx_start no earlier than N+2.

Widths and ranges:
- FIFO pointers are log2(FIFO_DEPTH)+1 bits so full and empty are distinguishable.
- ASCII index arithmetic is 8-bit.
- Score is zero-extended to 8 bits.

Test Plan:
- 'S' with rx_ready at cycle 10 -> cmd_start = 1 at cycle 11 only; no TX traffic (ECHO_EN = 0).
- 'H' then '3' (NUM_MOLES = 5) -> cmd_hit pulse with cmd_hit_onehot = 5'b01000, one cycle after the '3' strobe. 'H' then '7' -> rx_error pulse, no cmd_hit.
- game_active = 1, mole_positions 00001 -> 00100 -> 00000 with tx_busy modelled (busy for 100 cycles per byte) -> tx bytes '0', '2', '-' in order, each tx_start one cycle long, none issued while tx_busy = 1.
- game_over held high for 1000 cycles -> exactly one 'R'. Next game (game_active pulse, then game_over again) -> a second 'R'.
- 'Q' with score = 37 -> bytes 0x50 then 0x25, back to back in the FIFO with no byte between them, even when a mole change occurs in the same cycle (mole code follows the pair).
- FIFO_DEPTH = 4, tx_busy stuck high, 6 mole changes -> FIFO holds 4 bytes, drop_flag = 1. Release tx_busy -> 4 bytes drain; drop_flag stays 1 until reset.

Source files
------------

// File: rtl/game_uart_link_if.sv
// game_uart_link_if: byte-level handshake between the link engine (master) and the UART rx/tx cores (slave)
interface game_uart_link_if;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    modport master (input rx_data, rx_ready, tx_busy, output tx_start, tx_data);
    modport slave  (output rx_data, rx_ready, tx_busy, input tx_start, tx_data);
endinterface

// File: rtl/game_uart_link.sv
// game_uart_link: PC command decoder plus FIFO-buffered event reporter with tx_busy handshake
module game_uart_link #(
    parameter int NUM_MOLES  = 5,
    parameter int FIFO_DEPTH = 8,
    parameter int ECHO_EN    = 0,
    parameter int SCORE_BITS = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    game_uart_link_if.master      uart,
    input  logic                  game_active,
    input  logic                  game_over,
    input  logic [NUM_MOLES-1:0]  mole_positions,
    input  logic [SCORE_BITS-1:0] score,
    output logic                  cmd_start,
    output logic                  cmd_hit,
    output logic [NUM_MOLES-1:0]  cmd_hit_onehot,
    output logic                  rx_error,
    output logic                  drop_flag
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
    typedef enum logic {RX_IDLE, RX_IDX} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_WAIT_HI, TX_WAIT_LO} tx_state_t;
    rx_state_t rx_state;
    tx_state_t tx_state;
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, used;
    logic [NUM_MOLES-1:0] last_mole;
    logic over_armed, pend_mole, pend_over, pend_score, pend_score2, pend_echo;
    logic [7:0] mole_byte, score_byte, echo_byte, lowest, mole_code, hit_idx, wr_byte;
    logic rd_en, room1, room2, sel_s2, sel_p, sel_r, sel_m, sel_e, any_sel, wr_room, wr_en;
    logic mole_chg, hit_ok, echo_in;
    assign used     = wr_ptr - rd_ptr;
    assign rd_en    = tx_state == TX_IDLE && used != '0 && !uart.tx_busy;
    // A same-cycle pop frees one slot before the write lands
    assign room1    = used != DEPTH || rd_en;
    assign room2    = rd_en ? used != DEPTH : used < DEPTH - 1'b1;
    assign sel_s2   = pend_score2;
    assign sel_p    = !pend_score2 && pend_score;
    assign sel_r    = !pend_score2 && !pend_score && pend_over;
    assign sel_m    = !pend_score2 && !pend_score && !pend_over && pend_mole;
    assign sel_e    = !pend_score2 && !pend_score && !pend_over && !pend_mole && pend_echo;
    assign any_sel  = sel_s2 || sel_p || sel_r || sel_m || sel_e;
    assign wr_room  = sel_p ? room2 : room1;
    assign wr_en    = any_sel && wr_room;
    assign wr_byte  = sel_s2 ? score_byte : sel_p ? "P" : sel_r ? "R" : sel_m ? mole_byte : echo_byte;
    assign mole_chg = game_active && mole_positions != last_mole;
    assign mole_code = |mole_positions ? 8'h30 + lowest : "-";
    assign hit_idx  = uart.rx_data - 8'h30;
    assign hit_ok   = hit_idx < 8'(NUM_MOLES);
    assign echo_in  = ECHO_EN != 0 && uart.rx_ready;
    always_comb begin
        lowest = '0;
        for (int i = NUM_MOLES - 1; i >= 0; i--) if (mole_positions[i]) lowest = 8'(i);
    end
    always_ff @(posedge clock) if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_byte;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_state       <= RX_IDLE;
            tx_state       <= TX_IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            last_mole      <= '0;
            over_armed     <= 1'b1;
            pend_mole      <= 1'b0;
            pend_over      <= 1'b0;
            pend_score     <= 1'b0;
            pend_score2    <= 1'b0;
            pend_echo      <= 1'b0;
            mole_byte      <= '0;
            score_byte     <= '0;
            echo_byte      <= '0;
            cmd_start      <= 1'b0;
            cmd_hit        <= 1'b0;
            cmd_hit_onehot <= '0;
            rx_error       <= 1'b0;
            drop_flag      <= 1'b0;
            uart.tx_start  <= 1'b0;
            uart.tx_data   <= '0;
        end else begin
            cmd_start      <= 1'b0;
            cmd_hit        <= 1'b0;
            cmd_hit_onehot <= '0;
            rx_error       <= 1'b0;
            if (uart.rx_ready && rx_state == RX_IDX) begin
                rx_state       <= RX_IDLE;
                cmd_hit        <= hit_ok;
                cmd_hit_onehot <= hit_ok ? NUM_MOLES'(1) << hit_idx : '0;
                rx_error       <= !hit_ok;
            end else if (uart.rx_ready) begin
                cmd_start <= uart.rx_data == "S";
                rx_state  <= uart.rx_data == "H" ? RX_IDX : RX_IDLE;
            end
            // Clears for the served flag come first so a same-cycle new event wins
            pend_score2 <= sel_p && room2;
            if (sel_p) pend_score <= 1'b0;
            if (sel_p) score_byte <= 8'(score);
            if (uart.rx_ready && rx_state == RX_IDLE && uart.rx_data == "Q") pend_score <= 1'b1;
            if (sel_r) pend_over <= 1'b0;
            if (game_over && over_armed) begin
                pend_over  <= 1'b1;
                over_armed <= 1'b0;
            end else if (game_active && !game_over) over_armed <= 1'b1;
            if (sel_m) pend_mole <= 1'b0;
            if (mole_chg) begin
                pend_mole <= 1'b1;
                mole_byte <= mole_code;
                last_mole <= mole_positions;
            end
            if (sel_e) pend_echo <= 1'b0;
            if (echo_in) begin
                pend_echo <= 1'b1;
                echo_byte <= uart.rx_data;
            end
            drop_flag <= drop_flag || (any_sel && !wr_room) || (echo_in && pend_echo && !sel_e);
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            uart.tx_start <= rd_en;
            if (rd_en) begin
                uart.tx_data <= mem[rd_ptr[AW-1:0]];
                rd_ptr       <= rd_ptr + 1'b1;
            end
            tx_state <= rd_en ? TX_WAIT_HI :
                        tx_state == TX_WAIT_HI && uart.tx_busy ? TX_WAIT_LO :
                        tx_state == TX_WAIT_LO && !uart.tx_busy ? TX_IDLE : tx_state;
        end
    end
endmodule

// File: tb/tb_game_uart_link.sv
// tb_game_uart_link: scoreboard bench with a busy-for-100-cycles uart_tx model
module tb_game_uart_link;
    logic clock = 0, reset = 0;
    logic game_active = 0, game_over = 0, hold = 0;
    logic [4:0] mole_positions = '0;
    logic [5:0] score = '0;
    logic cmd_start, cmd_hit, rx_error, drop_flag;
    logic [4:0] cmd_hit_onehot;
    int n_vec = 0, n_err = 0, cyc = 0, bcnt = 0;
    logic [31:0] exp_tx[$], exp_cmd[$], exp_cyc[$];
    game_uart_link_if u();
    game_uart_link #(.NUM_MOLES(5), .FIFO_DEPTH(4), .ECHO_EN(0), .SCORE_BITS(6)) dut (
        .clock(clock), .reset(reset), .uart(u), .game_active(game_active), .game_over(game_over),
        .mole_positions(mole_positions), .score(score), .cmd_start(cmd_start), .cmd_hit(cmd_hit),
        .cmd_hit_onehot(cmd_hit_onehot), .rx_error(rx_error), .drop_flag(drop_flag));
    always #5 clock = ~clock;
    assign u.tx_busy = bcnt != 0 || hold;
    always @(posedge clock) cyc <= cyc + 1;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    always @(negedge clock) begin : mon
        logic [31:0] got;
        got = {24'b0, cmd_start, cmd_hit, rx_error, cmd_hit_onehot};
        if (u.tx_start) begin
            chk("tx_while_busy", {31'b0, u.tx_busy}, 0);
            chk("tx_byte", {24'b0, u.tx_data}, exp_tx.size() != 0 ? exp_tx.pop_front() : 32'hffffffff);
            bcnt <= 100;
        end else if (bcnt != 0) bcnt <= bcnt - 1;
        if (cmd_start || cmd_hit || rx_error) begin
            chk("cmd", got, exp_cmd.size() != 0 ? exp_cmd.pop_front() : 32'hffffffff);
            chk("cmd_cycle", cyc, exp_cyc.size() != 0 ? exp_cyc.pop_front() : 32'hffffffff);
        end
        if (!cmd_hit && cmd_hit_onehot != '0) chk("onehot_idle", {27'b0, cmd_hit_onehot}, 0);
    end
    task automatic send_rx(input logic [7:0] b, input bit has, input logic [7:0] e);
        @(posedge clock); #1;
        u.rx_data = b;
        u.rx_ready = 1;
        if (has) begin
            exp_cmd.push_back({24'b0, e});
            exp_cyc.push_back(cyc + 1);
        end
        @(posedge clock); #1;
        u.rx_ready = 0;
    endtask
    task automatic wait_idle();
        int t = 0;
        while ((exp_tx.size() != 0 || bcnt != 0) && t < 5000) begin
            @(posedge clock);
            t++;
        end
        repeat (20) @(posedge clock);
        chk("drain", exp_tx.size() + exp_cmd.size(), 0);
    endtask
    task automatic mole(input logic [4:0] m);
        @(posedge clock); #1;
        mole_positions = m;
        repeat (3) @(posedge clock);
    endtask
    function automatic logic [31:0] outs();
        return {14'b0, u.tx_start, u.tx_data, cmd_start, cmd_hit, cmd_hit_onehot, rx_error, drop_flag};
    endfunction
    initial begin
        u.rx_data = 0;
        u.rx_ready = 0;
        repeat (3) @(posedge clock);
        #1 chk("reset_outs", outs(), 0);
        reset = 1;
        repeat (6) @(posedge clock);
        send_rx("S", 1, 8'b100_00000);
        send_rx("X", 0, 0);
        send_rx("H", 0, 0);
        send_rx("3", 1, 8'b010_01000);
        send_rx("H", 0, 0);
        send_rx("7", 1, 8'b001_00000);
        send_rx("H", 0, 0);
        send_rx("4", 1, 8'b010_10000);
        send_rx("H", 0, 0);
        send_rx("5", 1, 8'b001_00000);
        send_rx("H", 0, 0);
        send_rx("S", 1, 8'b001_00000);
        send_rx("H", 0, 0);
        send_rx("/", 1, 8'b001_00000);
        send_rx("H", 0, 0);
        send_rx("0", 1, 8'b010_00001);
        repeat (10) @(posedge clock);
        chk("no_tx_after_cmds", {31'b0, u.tx_busy}, 0);
        #1 game_active = 1;
        exp_tx.push_back("0");
        exp_tx.push_back("2");
        exp_tx.push_back("-");
        mole(5'b00001);
        mole(5'b00100);
        mole(5'b00000);
        wait_idle();
        #1 game_active = 0;
        game_over = 1;
        exp_tx.push_back("R");
        repeat (1000) @(posedge clock);
        #1 game_over = 0;
        wait_idle();
        #1 game_active = 1;
        @(posedge clock); #1 game_active = 0;
        @(posedge clock); #1 game_over = 1;
        exp_tx.push_back("R");
        repeat (300) @(posedge clock);
        #1 game_over = 0;
        wait_idle();
        #1 game_active = 1;
        score = 6'd37;
        @(posedge clock); #1;
        u.rx_data = "Q";
        u.rx_ready = 1;
        mole_positions = 5'b00010;
        exp_tx.push_back("P");
        exp_tx.push_back(8'h25);
        exp_tx.push_back("1");
        @(posedge clock); #1 u.rx_ready = 0;
        wait_idle();
        #1 hold = 1;
        exp_tx.push_back("0");
        exp_tx.push_back("2");
        exp_tx.push_back("3");
        exp_tx.push_back("4");
        mole(5'b00001);
        mole(5'b00100);
        mole(5'b01000);
        chk("drop_before_q", {31'b0, drop_flag}, 0);
        send_rx("Q", 0, 0);
        repeat (3) @(posedge clock);
        chk("drop_score_no_room", {31'b0, drop_flag}, 1);
        mole(5'b10000);
        mole(5'b00011);
        mole(5'b00110);
        chk("drop_full", {31'b0, drop_flag}, 1);
        #1 hold = 0;
        wait_idle();
        chk("drop_sticky", {31'b0, drop_flag}, 1);
        #1 game_active = 0;
        reset = 0;
        repeat (2) @(posedge clock);
        #1 chk("reset_again", outs(), 0);
        reset = 1;
        repeat (5) @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
